// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type and renderer state encodings.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 460;
   localparam int unsigned V_ACTIVE = 462;
   localparam int unsigned COORD_W  = 11;
   localparam int unsigned PIX_W    = 10;
   localparam int unsigned COLOR_W  = 12;
   localparam int unsigned STATE_W  = 2;

   typedef logic [COLOR_W-1:0] color_t;

   localparam logic [STATE_W-1:0] IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] RUN    = 2'd1;
   localparam logic [STATE_W-1:0] PAUSED = 2'd2;

endpackage

// File: rtl/bouncing_box_renderer_if.sv
// Timing-generator to DAC pixel bus: scan position and raw sync in, colour and aligned sync out.
interface bouncing_box_renderer_if;
   import vga_pkg::*;

   logic [PIX_W-1:0] x_pos;
   logic [PIX_W-1:0] y_pos;
   logic             display_zone;
   logic             h_synk_in;
   logic             v_synk_in;
   logic [3:0]       vga_r;
   logic [3:0]       vga_g;
   logic [3:0]       vga_b;
   logic             h_synk;
   logic             v_synk;

   modport master (
      output x_pos, y_pos, display_zone, h_synk_in, v_synk_in,
      input  vga_r, vga_g, vga_b, h_synk, v_synk
   );

   modport slave (
      input  x_pos, y_pos, display_zone, h_synk_in, v_synk_in,
      output vga_r, vga_g, vga_b, h_synk, v_synk
   );

endinterface

// File: rtl/box_axis_mover.sv
// One axis of box motion: position, direction and edge bounce, advanced on move_i.
module box_axis_mover
   import vga_pkg::*;
#(
   parameter int unsigned SIZE  = 40,
   parameter int unsigned LIMIT = 460,
   parameter int unsigned STEP  = 2,
   parameter int unsigned INIT  = 100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               move_i,
   output logic [COORD_W-1:0] pos_o,
   output logic               edge_hit_c_o
);

   localparam logic [COORD_W-1:0] SIZE_C = COORD_W'(SIZE);
   localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
   localparam logic [COORD_W-1:0] LIM_C  = COORD_W'(LIMIT);
   localparam logic [COORD_W-1:0] MAX_C  = COORD_W'(LIMIT - SIZE);
   localparam logic [COORD_W-1:0] INIT_C = COORD_W'(INIT);

   logic [COORD_W-1:0] pos_q, pos_d;
   logic               dir_q, dir_d;   // 1 = increasing
   logic               hit_c;

   // Next position if a move happens this cycle; hit_c flags a wall contact.
   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      hit_c = 1'b0;
      if (dir_q) begin
         if (pos_q + SIZE_C + STEP_C >= LIM_C) begin
            pos_d = MAX_C;
            dir_d = 1'b0;
            hit_c = 1'b1;
         end else begin
            pos_d = pos_q + STEP_C;
         end
      end else begin
         if (pos_q <= STEP_C) begin
            pos_d = '0;
            dir_d = 1'b1;
            hit_c = 1'b1;
         end else begin
            pos_d = pos_q - STEP_C;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q <= INIT_C;
         dir_q <= 1'b1;
      end else if (move_i) begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign pos_o        = pos_q;
   assign edge_hit_c_o = hit_c;

endmodule

// File: rtl/bouncing_box_renderer.sv
// Draws a bouncing solid box over a background and re-aligns sync with the registered colour.
module bouncing_box_renderer
   import vga_pkg::*;
#(
   parameter int unsigned H_ACT     = H_ACTIVE,
   parameter int unsigned V_ACT     = V_ACTIVE,
   parameter int unsigned BOX_W     = 40,
   parameter int unsigned BOX_H     = 40,
   parameter int unsigned STEP      = 2,
   parameter int unsigned INIT_X    = 100,
   parameter int unsigned INIT_Y    = 100,
   parameter color_t      BOX_COLOR = 12'hF00,
   parameter color_t      BG_COLOR  = 12'h00F,
   parameter int unsigned SYNC_DLY  = 2
) (
   input  logic                    clk_50,
   input  logic                    rst,
   bouncing_box_renderer_if.slave  vga,
   input  logic                    pause,
   output logic [7:0]              bounce_count
);

   localparam logic [COORD_W-1:0] BOX_W_C = COORD_W'(BOX_W);
   localparam logic [COORD_W-1:0] BOX_H_C = COORD_W'(BOX_H);

   logic                v_prev_q;
   logic                tick_c;
   logic [STATE_W-1:0]  state_q, state_d;
   logic                move_c;
   logic [COORD_W-1:0]  box_x, box_y;
   logic                hit_x_c, hit_y_c;
   logic [7:0]          bounce_q, bounce_d;
   color_t              rgb_q, rgb_d;
   logic [COORD_W-1:0]  x_ext, y_ext;
   logic                in_box_c;
   logic [SYNC_DLY-1:0] hs_q, hs_d, vs_q, vs_d;

   // Frame tick on the falling edge of vertical sync.
   assign tick_c = v_prev_q & ~vga.v_synk_in;

   always_comb begin
      state_d = state_q;
      move_c  = 1'b0;
      if (tick_c) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN: begin
               if (pause) state_d = PAUSED;
               else       move_c  = 1'b1;
            end
            PAUSED: begin
               if (!pause) state_d = RUN;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   box_axis_mover #(
      .SIZE (BOX_W), .LIMIT(H_ACT), .STEP(STEP), .INIT(INIT_X)
   ) u_x (
      .clk(clk_50), .rst(rst), .move_i(move_c), .pos_o(box_x), .edge_hit_c_o(hit_x_c)
   );

   box_axis_mover #(
      .SIZE (BOX_H), .LIMIT(V_ACT), .STEP(STEP), .INIT(INIT_Y)
   ) u_y (
      .clk(clk_50), .rst(rst), .move_i(move_c), .pos_o(box_y), .edge_hit_c_o(hit_y_c)
   );

   // A corner hit is a single bounce.
   always_comb begin
      bounce_d = bounce_q;
      if (move_c && (hit_x_c || hit_y_c)) bounce_d = bounce_q + 8'd1;
   end

   assign x_ext    = COORD_W'(vga.x_pos);
   assign y_ext    = COORD_W'(vga.y_pos);
   assign in_box_c = (x_ext >= box_x) && (x_ext < box_x + BOX_W_C) &&
                     (y_ext >= box_y) && (y_ext < box_y + BOX_H_C);

   always_comb begin
      rgb_d = BG_COLOR;
      if (vga.display_zone) rgb_d = '0;
      else if (in_box_c)    rgb_d = BOX_COLOR;
   end

   always_comb begin
      hs_d    = hs_q;
      vs_d    = vs_q;
      hs_d[0] = vga.h_synk_in;
      vs_d[0] = vga.v_synk_in;
      for (int i = 1; i < SYNC_DLY; i++) begin
         hs_d[i] = hs_q[i-1];
         vs_d[i] = vs_q[i-1];
      end
   end

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         v_prev_q <= 1'b1;
         state_q  <= IDLE;
         bounce_q <= '0;
         rgb_q    <= '0;
         hs_q     <= '1;
         vs_q     <= '1;
      end else begin
         v_prev_q <= vga.v_synk_in;
         state_q  <= state_d;
         bounce_q <= bounce_d;
         rgb_q    <= rgb_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
      end
   end

   assign vga.vga_r    = rgb_q[11:8];
   assign vga.vga_g    = rgb_q[7:4];
   assign vga.vga_b    = rgb_q[3:0];
   assign vga.h_synk   = hs_q[SYNC_DLY-1];
   assign vga.v_synk   = vs_q[SYNC_DLY-1];
   assign bounce_count = bounce_q;

endmodule

// File: doc/bouncing_box_renderer.md
Name: bouncing_box_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing generator on the DE1 50 MHz design.
- Consumes x_pos, y_pos, display_zone and the raw h/v sync from the timing block, and drives registered RGB plus aligned sync to the DAC pins.
- Draws a solid rectangle over a background colour; the rectangle moves by STEP pixels once per frame and bounces off the active-area edges.

Parameters:
- H_ACTIVE, 460, active pixels per line (x_pos < H_ACTIVE is visible)
- V_ACTIVE, 462, active lines per frame
- BOX_W, 40, box width in pixels
- BOX_H, 40, box height in lines
- STEP, 2, pixels moved per frame on each axis
- INIT_X, 100, box left edge after reset
- INIT_Y, 100, box top edge after reset
- BOX_COLOR, 12'hF00, {R4,G4,B4} colour inside the box
- BG_COLOR, 12'h00F, colour of visible pixels outside the box
- SYNC_DLY, 2, pipeline depth applied to h/v sync (1..4)

Ports:
- clk_50  in  1  system clock, same clock as the timing generator
- rst  in  1  asynchronous, active-high reset
- x_pos  in  10  current pixel column
- y_pos  in  10  current line
- display_zone  in  1  0 = visible area, 1 = blanking (active-low visibility)
- h_synk_in  in  1  raw horizontal sync, active low
- v_synk_in  in  1  raw vertical sync, active low
- pause  in  1  1 = freeze box motion (sampled at frame tick)
- vga_r, vga_g, vga_b  out  4 each  registered colour
- h_synk  out  1  h_synk_in delayed SYNC_DLY cycles
- v_synk  out  1  v_synk_in delayed SYNC_DLY cycles
- bounce_count  out  8  number of edge bounces since reset, wraps 255->0

Behaviour:
- Reset (async, rst=1): box_x=INIT_X, box_y=INIT_Y, dir_x=+, dir_y=+, state=IDLE, rgb=0, h_synk/v_synk=1 and every sync delay stage=1, bounce_count=0, v_prev=1.
- Frame tick: single-cycle pulse when v_prev=1 and v_synk_in=0 (falling edge of v sync); v_prev is a register of v_synk_in.
- State machine (advances on frame tick only):
  - IDLE -> RUN on the first tick; box does not move.
  - RUN -> PAUSED on a tick with pause=1; otherwise update position.
  - PAUSED -> RUN on a tick with pause=0; no update on that tick. Movement resumes on the next tick.
- Position update, X axis (Y identical with BOX_H/V_ACTIVE), 11-bit arithmetic:
  - dir + and box_x+BOX_W+STEP >= H_ACTIVE: box_x=H_ACTIVE-BOX_W, dir flips, bounce.
  - dir - and box_x <= STEP: box_x=0, dir flips, bounce.
  - Otherwise box_x +/- STEP.
- Bounce counting: bounce_count increments by 1 per tick if either axis bounced. A corner hit (both axes at once) counts as 1.
- Pixel path, 1-cycle latency:
  - rgb <= 0 when display_zone=1.
  - Otherwise BOX_COLOR if box_x <= x_pos < box_x+BOX_W and box_y <= y_pos < box_y+BOX_H, else BG_COLOR.
  - Comparisons are unsigned 11-bit.
- Box-position timing: box position changes only at the tick, i.e. during vertical blanking, so no tearing within a frame.
- Sync outputs are a pure shift register of depth SYNC_DLY; default 2 aligns with the registered x_pos plus the registered rgb.
- Reset mid-frame forces rgb=0 and sync=1 immediately. After release the box restarts at INIT in IDLE.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE/V_ACTIVE constants
  - 12-bit colour typedef
  - state enum {IDLE, RUN, PAUSED}
- One natural sub-module: box_axis_mover (single axis position/direction/bounce, parameterised by size/limit/step/init), instantiated twice.

Test Plan:
- Reset: assert rst mid-line -> rgb=0, h_synk=v_synk=1, bounce_count=0, box at (100,100) within the same cycle.
- Motion: release reset, 4 v_synk falling edges -> first tick IDLE->RUN, then box_x=box_y=106.
- Right/bottom bounce: INIT_X=416, INIT_Y=100, 4 ticks -> box_x 416, 418, 420 (dir flips, bounce_count=1), 418.
- Corner: INIT_X=INIT_Y=418, BOX_W=BOX_H=40, H_ACTIVE=V_ACTIVE=460; after IDLE tick, 2 ticks -> both axes reach 420 on the same tick, bounce_count=1.
- Render: box at (100,100); x_pos=100/y_pos=100/display_zone=0 -> next cycle rgb=F00; x_pos=140 -> 00F; display_zone=1 -> 000.
- Pause: pause=1 over 3 ticks -> position constant; pause=0 -> resume tick does not move, next tick moves +2. Also check h/v sync outputs lag inputs by exactly 2 cycles.
